popcount_seq_ctrl: RTL and testbench
====================================

Name: popcount_seq_ctrl

Overview:
- Sequencing controller that computes the population count of a wide word using one shared 8-bit ones-counter (count1s_8bit) instantiated outside this block.
- Accepts a word on a valid/ready input handshake, feeds it to the counter one byte per cycle (LSB byte first), and accumulates the 4-bit partial counts.
- Presents the total on a valid/ready output handshake.
- Sits between a requester and the shared count1s_8bit instance.

Parameters:
- NBYTES, 4, number of bytes per input word (>=1); word width W = 8*NBYTES.
- CW, 6, width of the result count; must satisfy 2^CW > 8*NBYTES.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  controller can accept a word.
- in_data  input  8*NBYTES  word to count.
- cnt_byte  output  8  byte driven to count1s_8bit.register.
- cnt_ones  input  4  count1s_8bit.numOnes, combinational return in the same cycle.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_count  output  CW  number of ones in the accepted word.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset values (asynchronous on rst_n low):
  - state = IDLE; internal shift register, accumulator and byte index all 0.
  - out_count = 0, out_valid = 0, busy = 0, in_ready = 1, cnt_byte = 0.
- Reset is honoured in any state. Reset mid-RUN or mid-DONE discards the word and any pending result; no out_valid pulse follows.
- States:
  - IDLE: in_ready = 1; cnt_byte = 0. When in_valid is high at a clock edge:
    - capture in_data into the shift register;
    - acc <= 0, idx <= 0;
    - go to RUN.
  - RUN: in_ready = 0; cnt_byte = shreg[7:0] (combinational from the register). Each edge:
    - acc <= acc + zero-extended cnt_ones;
    - shreg shifts right by 8, zero-filling;
    - idx <= idx + 1.
    - When idx == NBYTES-1: out_count <= acc + cnt_ones, out_valid <= 1, go to DONE.
  - DONE: in_ready = 0; cnt_byte = 0; out_valid = 1; out_count held stable. On an edge with out_ready high: out_valid <= 0, go to IDLE. out_count keeps its last value after leaving DONE.
- Latency:
  - Accept at edge t. out_valid is high after edge t+NBYTES.
  - Minimum period between accepts is NBYTES+2 cycles (out_ready tied high).
- Handshakes:
  - in_valid outside IDLE is ignored; the requester must hold it.
  - out_count and out_valid must not change while out_valid=1 and out_ready=0.
  - out_ready outside DONE has no effect.
- Arithmetic:
  - Accumulation is unsigned, CW bits wide.
  - The CW rule guarantees no overflow for a legal cnt_ones (0..8).
  - cnt_ones values 9..15 are illegal; the block adds them unclamped and does not flag them.
- NBYTES = 1: RUN lasts exactly one cycle, and out_count = cnt_ones on that cycle.
- busy = (state != IDLE).

Test Plan:
- Word 0xFFFFFFFF, out_ready=1 -> cnt_byte sequence FF,FF,FF,FF on 4 consecutive cycles; out_valid high 4 cycles after accept; out_count=32.
- Word 0x00000000, then 0x80402011 back-to-back -> out_count=0, then out_count=5; second in_ready rise exactly 1 cycle after the first out handshake.
- Word 0x0F0F00FF with out_ready held low for 5 cycles -> out_valid and out_count=16 stable for all 5 cycles; in_ready=0 throughout; IDLE entered one edge after out_ready rises.
- in_valid pulsed with word 0xFFFF0000 during RUN of word 0x00000001 -> pulsed word ignored; result 1.
- rst_n asserted low asynchronously in the 2nd RUN cycle -> all outputs at reset values immediately; after release, word 0x000000FF gives 8 with no stale result.
- NBYTES=1, CW=4, word 0xA5 -> one RUN cycle with cnt_byte=A5; out_count=4.

Source files
------------

// File: rtl/popcount_seq_ctrl.sv
// rtl/popcount_seq_ctrl.sv - byte-serial popcount sequencer driving a shared 8-bit ones-counter
module popcount_seq_ctrl #(
  parameter int NBYTES = 4,
  parameter int CW     = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_data,
  output logic [7:0]            cnt_byte,
  input  logic [3:0]            cnt_ones,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW-1:0]         out_count,
  output logic                  busy
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    shreg;
  logic [CW-1:0]   acc;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   ones_ext;

  // Illegal counts 9..15 are passed through unclamped on purpose.
  assign ones_ext = CW'(cnt_ones);

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign cnt_byte = (state == RUN) ? shreg[7:0] : 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      acc       <= '0;
      idx       <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= in_data;
            acc   <= '0;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc + ones_ext;
          shreg <= shreg >> 8;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            out_count <= acc + ones_ext;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// tb/tb_popcount_seq_ctrl.sv - randomized self-checking bench for popcount_seq_ctrl
module tb_popcount_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  cnt_byte;
  logic [3:0]  cnt_ones;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_count;
  logic        busy;

  logic        in_valid1;
  logic        in_ready1;
  logic [7:0]  in_data1;
  logic [7:0]  cnt_byte1;
  logic [3:0]  cnt_ones1;
  logic        out_valid1;
  logic        out_ready1;
  logic [3:0]  out_count1;
  logic        busy1;

  int n_tests = 0;
  int n_fail  = 0;

  popcount_seq_ctrl #(.NBYTES(4), .CW(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .cnt_byte(cnt_byte), .cnt_ones(cnt_ones),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .busy(busy)
  );

  popcount_seq_ctrl #(.NBYTES(1), .CW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .cnt_byte(cnt_byte1), .cnt_ones(cnt_ones1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_count(out_count1), .busy(busy1)
  );

  // Stand-ins for the external count1s_8bit instances.
  assign cnt_ones  = 4'($countones(cnt_byte));
  assign cnt_ones1 = 4'($countones(cnt_byte1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offers a word, follows it byte by byte, optionally stalls the consumer,
  // and optionally pulses a decoy word during the first RUN cycle.
  task automatic run_word(input logic [31:0] w, input int stall, input bit decoy, input string tag);
    logic [5:0] exp_cnt;
    int n;
    exp_cnt = 6'($countones(w));
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = w;
    out_ready = (stall == 0);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL %s accept_timeout: in_ready=%0b want 1", tag, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (decoy && i == 0) begin
        in_valid = 1'b1;
        in_data  = 32'hFFFF0000;
      end else if (decoy && i == 1) begin
        in_valid = 1'b0;
      end
      n_tests++;
      if (cnt_byte !== w[8*i +: 8] || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s run_byte%0d: cnt_byte=%h in_ready=%b busy=%b out_valid=%b want %h 0 1 0",
                 tag, i, cnt_byte, in_ready, busy, out_valid, w[8*i +: 8]);
      end
      @(negedge clk);
    end
    n_tests++;
    if (out_valid !== 1'b1 || out_count !== exp_cnt || cnt_byte !== 8'd0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done: out_valid=%b out_count=%0d cnt_byte=%h in_ready=%b want 1 %0d 00 0",
               tag, out_valid, out_count, cnt_byte, in_ready, exp_cnt);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || out_count !== exp_cnt || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s stall%0d: out_valid=%b out_count=%0d in_ready=%b busy=%b want 1 %0d 0 1",
                 tag, s, out_valid, out_count, in_ready, busy, exp_cnt);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL %s release: in_ready=%b out_valid=%b busy=%b out_count=%0d want 1 0 0 %0d",
               tag, in_ready, out_valid, busy, out_count, exp_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
    #12;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || cnt_byte !== 8'd0 || out_count !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b cnt_byte=%h out_count=%0d want 1 0 0 00 0",
               in_ready, out_valid, busy, cnt_byte, out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_all_ones();
    run_word(32'hFFFFFFFF, 0, 1'b0, "all_ones");
  endtask

  task automatic test_back_to_back();
    run_word(32'h00000000, 0, 1'b0, "b2b_zero");
    run_word(32'h80402011, 0, 1'b0, "b2b_five");
  endtask

  task automatic test_stall();
    run_word(32'h0F0F00FF, 5, 1'b0, "stall");
  endtask

  task automatic test_ignore_in_run();
    run_word(32'h00000001, 0, 1'b1, "ignore");
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_no_accept: busy=%b want 0", busy);
    end
  endtask

  task automatic test_async_reset();
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h12345678;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || cnt_byte !== 8'd0 || out_count !== 6'd0) begin
      n_fail++;
      $display("FAIL async_reset: in_ready=%b out_valid=%b busy=%b cnt_byte=%h out_count=%0d want 1 0 0 00 0",
               in_ready, out_valid, busy, cnt_byte, out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_stale%0d: out_valid=%b busy=%b want 0 0", i, out_valid, busy);
      end
    end
    run_word(32'h000000FF, 0, 1'b0, "post_reset");
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int k = 0; k < 20; k++) begin
      w = $urandom;
      if (k == 0) w = 32'h00000001;
      run_word(w, int'($urandom_range(0, 3)), 1'b0, $sformatf("rand%0d", k));
    end
  endtask

  task automatic test_single_byte();
    int n;
    @(negedge clk);
    in_valid1  = 1'b1;
    in_data1   = 8'hA5;
    out_ready1 = 1'b1;
    n = 0;
    while (!in_ready1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid1 = 1'b0;
    n_tests++;
    if (cnt_byte1 !== 8'hA5 || busy1 !== 1'b1 || out_valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL nb1_run: cnt_byte=%h busy=%b out_valid=%b want a5 1 0", cnt_byte1, busy1, out_valid1);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid1 !== 1'b1 || out_count1 !== 4'd4 || cnt_byte1 !== 8'd0) begin
      n_fail++;
      $display("FAIL nb1_done: out_valid=%b out_count=%0d cnt_byte=%h want 1 4 00", out_valid1, out_count1, cnt_byte1);
    end
    @(negedge clk);
    n_tests++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL nb1_release: in_ready=%b out_valid=%b want 1 0", in_ready1, out_valid1);
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_back_to_back();
    test_stall();
    test_ignore_in_run();
    test_single_byte();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
